// File: rtl/redun_result_capture.sv
// redun_result_capture: squarer run control and redundant-to-binary result conversion.
// Optional RUN watchdog enabled by defining REDUN_CAPTURE_TIMEOUT_EN.
module redun_result_capture #(
   parameter int NUM_WORDS  = 65,
   parameter int WORD_BITS  = 16,
   parameter int REDUN_BITS = 1,
   parameter int ITER_BITS  = 32,
   parameter int TIMEOUT    = 4096
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic                              i_locked,
   input  logic                              i_arm,
   input  logic [ITER_BITS-1:0]              i_iterations,
   output logic                              o_start,
   input  logic                              i_sq_valid,
   input  logic [NUM_WORDS*(WORD_BITS+REDUN_BITS)-1:0] i_sq_out,
   output logic [NUM_WORDS*WORD_BITS-1:0]    o_result,
   output logic [REDUN_BITS:0]               o_carry,
   output logic                              o_valid,
   input  logic                              i_ready,
   output logic                              o_busy,
   output logic [ITER_BITS-1:0]              o_count,
   output logic                              o_error
);

   localparam int W  = WORD_BITS + REDUN_BITS;
   localparam int CW = REDUN_BITS + 1;
   localparam int KW = $clog2(NUM_WORDS + 1);
   localparam int RW = NUM_WORDS * WORD_BITS;

   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("TIMEOUT must be at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_LOCK, S_RUN, S_CONVERT, S_HOLD
   } state_t;

   state_t                 state;
   logic [ITER_BITS-1:0]   target;
   logic [NUM_WORDS*W-1:0] cap;
   logic [CW-1:0]          carry;
   logic [KW-1:0]          idx;
   logic [W:0]             sum;
   logic [ITER_BITS-1:0]   cnt_inc;
   logic                   wdog_hit;

   // Captured words are consumed from the bottom; results shift in from the top.
   assign sum     = {1'b0, cap[W-1:0]} + {{WORD_BITS{1'b0}}, carry};
   assign cnt_inc = (&o_count) ? o_count : o_count + ITER_BITS'(1);
   assign o_busy  = (state != S_IDLE);

`ifdef REDUN_CAPTURE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wdog;

   always_ff @(posedge i_clk) begin
      if (i_reset || state != S_RUN || i_sq_valid)
         wdog <= '0;
      else
         wdog <= wdog + TW'(1);
   end

   assign wdog_hit = (wdog == TW'(TIMEOUT - 1));
`else
   assign wdog_hit = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= S_IDLE;
         target   <= '0;
         cap      <= '0;
         carry    <= '0;
         idx      <= '0;
         o_start  <= 1'b0;
         o_valid  <= 1'b0;
         o_count  <= '0;
         o_error  <= 1'b0;
         o_result <= '0;
         o_carry  <= '0;
      end else begin
         o_start <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (i_arm && i_iterations != '0) begin
                  o_count <= '0;
                  o_error <= 1'b0;
                  target  <= i_iterations;
                  if (i_locked) begin
                     o_start <= 1'b1;
                     state   <= S_RUN;
                  end else begin
                     state <= S_WAIT_LOCK;
                  end
               end
            end
            S_WAIT_LOCK: begin
               if (i_locked) begin
                  o_start <= 1'b1;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               if (!i_locked || (!i_sq_valid && wdog_hit)) begin
                  o_error <= 1'b1;
                  state   <= S_IDLE;
               end else if (i_sq_valid) begin
                  o_count <= cnt_inc;
                  if (cnt_inc == target) begin
                     cap   <= i_sq_out;
                     carry <= '0;
                     idx   <= '0;
                     state <= S_CONVERT;
                  end
               end
            end
            S_CONVERT: begin
               if (idx == KW'(NUM_WORDS)) begin
                  o_carry <= carry;
                  o_valid <= 1'b1;
                  state   <= S_HOLD;
               end else begin
                  o_result <= {sum[WORD_BITS-1:0], o_result[RW-1:WORD_BITS]};
                  carry    <= sum[W:WORD_BITS];
                  cap      <= cap >> W;
                  idx      <= idx + KW'(1);
               end
            end
            S_HOLD: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_redun_result_capture.sv
// tb_redun_result_capture: directed vectors for redun_result_capture
// with NUM_WORDS=4, WORD_BITS=16, REDUN_BITS=1, TIMEOUT=16.
module tb_redun_result_capture;

   localparam int NW = 4;
   localparam int WB = 16;
   localparam int RB = 1;
   localparam int IB = 32;
   localparam int W  = WB + RB;

   logic              clk = 1'b0;
   logic              reset;
   logic              locked;
   logic              arm;
   logic [IB-1:0]     iterations;
   logic              start;
   logic              sq_valid;
   logic [NW*W-1:0]   sq_out;
   logic [NW*WB-1:0]  result;
   logic [RB:0]       carry;
   logic              valid;
   logic              ready;
   logic              busy;
   logic [IB-1:0]     count;
   logic              error;

   int n_cmp = 0;
   int n_bad = 0;

   redun_result_capture #(
      .NUM_WORDS  (NW),
      .WORD_BITS  (WB),
      .REDUN_BITS (RB),
      .ITER_BITS  (IB),
      .TIMEOUT    (16)
   ) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_locked     (locked),
      .i_arm        (arm),
      .i_iterations (iterations),
      .o_start      (start),
      .i_sq_valid   (sq_valid),
      .i_sq_out     (sq_out),
      .o_result     (result),
      .o_carry      (carry),
      .o_valid      (valid),
      .i_ready      (ready),
      .o_busy       (busy),
      .o_count      (count),
      .o_error      (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NW*W-1:0] pack4(input logic [W-1:0] w3,
      input logic [W-1:0] w2, input logic [W-1:0] w1, input logic [W-1:0] w0);
      return {w3, w2, w1, w0};
   endfunction

   task automatic wait_valid(output int lat);
      lat = 0;
      while (valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic pulse_valid(input logic [NW*W-1:0] d);
      sq_valid = 1'b1;
      sq_out   = d;
      tick();
      sq_valid = 1'b0;
   endtask

   initial begin
      int lat;
      int n;
      logic stable;
      logic saw;
      logic [NW*WB-1:0] res0;

      reset = 1'b1; locked = 1'b1; arm = 1'b0; iterations = '0;
      sq_valid = 1'b0; sq_out = '0; ready = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      check("rst_ctl", {start, valid, busy, error}, 4'b0);
      check("rst_count", count, 0);
      check("rst_data", {result, carry}, 0);

      // zero target is ignored
      arm = 1'b1; iterations = 0;
      tick();
      arm = 1'b0;
      check("zero_arm_start", start, 0);
      tick();
      check("zero_arm_busy", {start, busy}, 2'b00);

      // single iteration
      arm = 1'b1; iterations = 1;
      tick();
      arm = 1'b0;
      check("one_start", {start, busy}, 2'b11);
      tick();
      check("one_start_end", start, 0);
      repeat (8) tick();
      pulse_valid(pack4(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF));
      wait_valid(lat);
      check("one_latency", lat, 5);
      check("one_result", result, 64'h0001_0001_0000_FFFF);
      check("one_carry", carry, 2);
      check("one_count", count, 1);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check("one_handshake", {valid, busy}, 2'b00);

      // multi-iteration, late valid during conversion
      arm = 1'b1; iterations = 3;
      tick();
      arm = 1'b0;
      check("multi_start", start, 1);
      tick();
      pulse_valid(pack4(17'h00001, 17'h00001, 17'h00001, 17'h00001));
      tick();
      pulse_valid(pack4(17'h00005, 17'h00006, 17'h00007, 17'h00008));
      tick();
      pulse_valid(pack4(17'h10000, 17'h0ABCD, 17'h1FFFF, 17'h12345));
      check("multi_count3", count, 3);
      pulse_valid(pack4(17'h0AAAA, 17'h0AAAA, 17'h0AAAA, 17'h0AAAA));
      wait_valid(lat);
      check("multi_latency", lat, 4);
      check("multi_count", count, 3);
      check("multi_result", result, 64'h0000_ABCF_0000_2345);
      check("multi_carry", carry, 1);

      // backpressure
      res0 = result;
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (valid !== 1'b1 || result !== res0 || carry !== 2'd1)
            stable = 1'b0;
      end
      check("hold_stable", stable, 1);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check("hold_release", {valid, busy}, 2'b00);
      arm = 1'b1; iterations = 1;
      tick();
      arm = 1'b0;
      check("rearm_start", start, 1);

      // lock loss coinciding with a valid aborts without capture
      locked = 1'b0;
      pulse_valid(pack4(17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h0FFFF));
      check("lock_loss", {error, busy, valid}, 3'b100);
      repeat (8) tick();
      check("lock_loss_quiet", {valid, result}, {1'b0, res0});

      // arm while unlocked waits for lock
      arm = 1'b1; iterations = 2;
      tick();
      arm = 1'b0;
      check("wait_lock", {start, busy, error}, 3'b010);
      saw = 1'b0;
      repeat (4) begin
         tick();
         if (start) saw = 1'b1;
      end
      check("wait_lock_nostart", saw, 0);
      locked = 1'b1;
      tick();
      check("lock_start", start, 1);

`ifdef REDUN_CAPTURE_TIMEOUT_EN
      n = 0;
      while (error !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("timeout_cycles", n, 16);
      check("timeout_idle", busy, 0);
`else
      repeat (100) tick();
      check("no_timeout", {busy, error}, 2'b10);
`endif

      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("final_reset", {busy, valid, start, count}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
